// File: rtl/riscv_store_unit.sv
// riscv_store_unit
//   Store path into a word-wide data RAM that has no byte enables.
//   SW writes the captured word directly. SB/SH do a read-modify-write:
//   read the aligned word, merge the store lane(s), write the word back.
//   Misaligned or unknown-width stores retire with an err pulse and touch
//   no memory.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   req_valid       store request valid (held by requester until accepted)
//   req_ready       high only in IDLE (and never while in reset)
//   req_addr        byte address of the store
//   req_wdata       store data, taken from the low bits
//   req_sel         store width: MASK_B / MASK_H / MASK_X, anything else is illegal
//   mem_addr        word-aligned RAM address (0 when not accessing RAM)
//   mem_re          RAM read strobe; mem_rdata valid the following cycle
//   mem_rdata       RAM read data
//   mem_we          RAM write strobe
//   mem_wdata       RAM write data (0 outside a write)
//   done            one-cycle pulse when a request retires
//   err             one-cycle pulse with done for a rejected request
module riscv_store_unit #(
   parameter int WORD_LENGTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [WORD_LENGTH-1:0] req_addr,
   input  logic [WORD_LENGTH-1:0] req_wdata,
   input  logic [1:0]             req_sel,
   output logic [WORD_LENGTH-1:0] mem_addr,
   output logic                   mem_re,
   input  logic [WORD_LENGTH-1:0] mem_rdata,
   output logic                   mem_we,
   output logic [WORD_LENGTH-1:0] mem_wdata,
   output logic                   done,
   output logic                   err
);

   // Store-width encodings shared with the load-side mask logic.
   localparam logic [1:0] MASK_B = 2'b00;
   localparam logic [1:0] MASK_H = 2'b01;
   localparam logic [1:0] MASK_X = 2'b10;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   logic [2:0]             state;
   logic [WORD_LENGTH-1:0] addr_q;
   logic [WORD_LENGTH-1:0] data_q;
   logic [1:0]             sel_q;
   logic                   req_bad;
   logic [WORD_LENGTH-1:0] merged;
   logic [WORD_LENGTH-1:0] addr_aligned;

   // Reject misaligned halfword/word and any unknown width.
   always_comb begin
      req_bad = 1'b0;
      case (req_sel)
         MASK_B:  req_bad = 1'b0;
         MASK_H:  req_bad = req_addr[0];
         MASK_X:  req_bad = (req_addr[1:0] != 2'b00);
         default: req_bad = 1'b1;
      endcase
   end

   // Overlay the store lane onto the word read back from RAM. Only the low
   // byte/halfword of the captured data is used, so upper bits are ignored.
   always_comb begin
      merged = mem_rdata;
      if (sel_q == MASK_B)
         merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
      else
         merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         addr_q <= '0;
         data_q <= '0;
         sel_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q <= req_addr;
                  data_q <= req_wdata;
                  sel_q  <= req_sel;
                  if (req_bad)
                     state <= S_ERR;
                  else if (req_sel == MASK_X)
                     state <= S_WRITE;
                  else
                     state <= S_READ;
               end
            end
            S_READ:  state <= S_WAIT;
            S_WAIT: begin
               // data_q is reused to hold the merged word for the write-back.
               data_q <= merged;
               state  <= S_WRITE;
            end
            S_WRITE: state <= S_IDLE;
            S_ERR:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign addr_aligned = {addr_q[WORD_LENGTH-1:2], 2'b00};

   // Outputs are gated by rst_n so nothing leaks out while reset is held,
   // even if reset arrives mid-operation before the next edge.
   assign req_ready = rst_n && (state == S_IDLE);
   assign mem_re    = rst_n && (state == S_READ);
   assign mem_we    = rst_n && (state == S_WRITE);
   assign done      = rst_n && ((state == S_WRITE) || (state == S_ERR));
   assign err       = rst_n && (state == S_ERR);
   assign mem_addr  = (rst_n && ((state == S_READ) || (state == S_WAIT) || (state == S_WRITE)))
                      ? addr_aligned : '0;
   assign mem_wdata = mem_we ? data_q : '0;

endmodule

// File: tb/tb_riscv_store_unit.sv
// Scoreboard bench for riscv_store_unit: a driver issues directed and random
// stores and pushes the expected retirement (computed from a shadow memory
// with mask arithmetic) into a queue; a negedge monitor pops and compares
// whenever the DUT reports done, and checks strobes/idle outputs every cycle.
module tb_riscv_store_unit;

   localparam logic [1:0] MASK_B   = 2'b00;
   localparam logic [1:0] MASK_H   = 2'b01;
   localparam logic [1:0] MASK_X   = 2'b10;
   localparam logic [1:0] MASK_BAD = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [1:0]  req_sel = '0;
   logic [31:0] mem_addr, mem_rdata, mem_wdata;
   logic        mem_re, mem_we, done, err;

   always #5 clk = ~clk;

   riscv_store_unit #(.WORD_LENGTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .done(done), .err(err)
   );

   // Word RAM with one-cycle read latency.
   logic [31:0] ram [256];
   logic [31:0] rdata_q;
   assign mem_rdata = rdata_q;
   always @(posedge clk) begin
      if (mem_re) rdata_q <= ram[mem_addr[9:2]];
      if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          acc;     // cycle number as seen by the monitor right after the accept edge
      bit          sub;
      bit          e;
      logic [31:0] addr;
      logic [31:0] wd;
      bit          waited;  // request was presented while the unit was busy
   } exp_t;

   exp_t        q[$];
   logic [31:0] ref_mem [256];
   int          compared = 0;
   int          mismatched = 0;
   bit          abort_pend = 1'b0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
      compared++;
      if (act !== expv) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   int   last_done = -100;
   bit   prev_rst = 1'b0;
   exp_t e;
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_ready", {31'd0, req_ready}, 32'd0);
         chk("rst_strobes", {28'd0, mem_re, mem_we, done, err}, 32'd0);
         chk("rst_addr", mem_addr, 32'd0);
         chk("rst_wdata", mem_wdata, 32'd0);
      end else begin
         if (!prev_rst) chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
         chk("re_we_exclusive", {31'd0, mem_re & mem_we}, 32'd0);
         if (q.size() > 0 && cyc >= q[0].acc)
            chk("busy_ready", {31'd0, req_ready}, 32'd0);
         if (mem_re) begin
            if (q.size() == 0) begin
               if (!abort_pend) chk("unexpected_re", 32'd1, 32'd0);
            end else begin
               chk("re_is_subword", {31'd0, q[0].sub}, 32'd1);
               chk("re_cycle", cyc, q[0].acc);
               chk("re_addr", mem_addr, {q[0].addr[31:2], 2'b00});
            end
         end
         if (done) begin
            if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
               e = q.pop_front();
               chk("err", {31'd0, err}, {31'd0, e.e});
               chk("done_latency", cyc, e.acc + (e.sub ? 2 : 0));
               if (e.e) begin
                  chk("err_strobes", {30'd0, mem_re, mem_we}, 32'd0);
               end else begin
                  chk("we", {31'd0, mem_we}, 32'd1);
                  chk("wr_addr", mem_addr, {e.addr[31:2], 2'b00});
                  chk("wr_data", mem_wdata, e.wd);
               end
               if (e.waited) chk("b2b_accept", e.acc, last_done + 2);
               last_done = cyc;
            end
         end else begin
            chk("we_err_without_done", {30'd0, mem_we, err}, 32'd0);
         end
         if (req_ready) begin
            chk("idle_addr", mem_addr, 32'd0);
            chk("idle_wdata", mem_wdata, 32'd0);
         end
      end
      prev_rst = rst_n;
   end

   // ---------------- driver + reference model ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model(logic [31:0] a, logic [31:0] d, logic [1:0] s, output exp_t x);
      int          nb;
      int          sh;
      logic [63:0] m;
      logic [63:0] t;
      x.addr = a;
      x.e    = (s == MASK_BAD) || (s == MASK_H && a[0]) || (s == MASK_X && a[1:0] != 2'b00);
      x.sub  = !x.e && (s != MASK_X);
      x.wd   = '0;
      if (!x.e) begin
         nb = (s == MASK_B) ? 1 : (s == MASK_H) ? 2 : 4;
         sh = 8 * int'(a[1:0]);
         m  = ((64'd1 << (8 * nb)) - 64'd1) << sh;
         t  = ({32'd0, ref_mem[a[9:2]]} & ~m) | (({32'd0, d} << sh) & m);
         x.wd = t[31:0];
         ref_mem[a[9:2]] = x.wd;
      end
   endtask

   task automatic issue(logic [31:0] a, logic [31:0] d, logic [1:0] s);
      exp_t x;
      int   n = 0;
      bit   w = 1'b0;
      req_valid = 1'b1; req_addr = a; req_wdata = d; req_sel = s;
      while (!req_ready && n < 40) begin
         w = 1'b1;
         step();
         n++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      model(a, d, s, x);
      x.acc    = cyc + 1;
      x.waited = w;
      q.push_back(x);
      step();
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 50) begin
         step();
         n++;
      end
      if (q.size() > 0) chk("drain_timeout", q.size(), 32'd0);
   endtask

   initial begin
      logic [31:0] v;
      logic [31:0] a;
      logic [1:0]  s;
      int          r;
      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         ram[i] <= v;
         ref_mem[i] = v;
      end
      ram[8'h80] <= 32'h11223344; ref_mem[8'h80] = 32'h11223344;
      ram[8'hC0] <= 32'hAAAAAAAA; ref_mem[8'hC0] = 32'hAAAAAAAA;

      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // Directed cases, issued back-to-back with req_valid held.
      issue(32'h100, 32'hDEADBEEF, MASK_X);
      issue(32'h202, 32'hFFFFFFAB, MASK_B);
      issue(32'h302, 32'h00001234, MASK_H);
      issue(32'h401, 32'h0000BEEF, MASK_H);
      issue(32'h402, 32'hCAFEF00D, MASK_X);
      drain();
      repeat (3) step();
      chk("ram_sw", ram[8'h40], 32'hDEADBEEF);
      chk("ram_sb_lane2", ram[8'h80], 32'h11AB3344);
      chk("ram_sh_upper", ram[8'hC0], 32'h1234AAAA);

      // Reset during WAIT abandons the store.
      abort_pend = 1'b1;
      req_valid = 1'b1; req_addr = 32'h204; req_wdata = 32'h00000055; req_sel = MASK_B;
      step();                 // accepted, now READ
      req_valid = 1'b0;
      step();                 // WAIT
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (5) step();
      abort_pend = 1'b0;
      chk("abort_no_write", ram[8'h81], ref_mem[8'h81]);

      // Random traffic.
      for (int k = 0; k < 300; k++) begin
         r = int'($urandom_range(0, 3));
         if (r > 1) repeat (r - 1) step();
         r = int'($urandom_range(0, 9));
         s = (r == 0) ? MASK_BAD : (r < 4) ? MASK_B : (r < 7) ? MASK_H : MASK_X;
         a = $urandom_range(0, 1023);
         if ($urandom_range(0, 1) == 1) begin
            if (s == MASK_H) a[0] = 1'b0;
            if (s == MASK_X) a[1:0] = 2'b00;
         end
         issue(a, $urandom, s);
      end
      drain();
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
